fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : program counter / fetch control for a small ROM-based core
// Optional feature macro: INST_COUNT_EN (adds saturating retire counter output)
// Revision: 1.0
// ============================================================================
module fetch_sequencer (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic [7:0] start_addr_i,
  input  logic [7:0] inst_i,
  input  logic       stall_i,
  input  logic       branch_fwd_i,
  input  logic       branch_back_i,
  input  logic       taken_i,
  input  logic [7:0] offset_i,
  output logic [7:0] pc_o,
  output logic       inst_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fault_o
`ifdef INST_COUNT_EN
  ,
  output logic [15:0] inst_count_o
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  localparam logic [7:0] C_INST_HALT    = 8'h88;
  localparam logic [7:0] C_INST_ILLEGAL = 8'hFF;

  logic [1:0] r_state;
  logic [7:0] r_pc;
  logic [1:0] w_state_nxt;
  logic [7:0] w_pc_nxt;
  logic       w_retire;
  logic       w_start_acc;
  logic [7:0] w_pc_inc;
  logic [7:0] w_pc_fwd;
  logic [7:0] w_pc_back;

  assign w_retire    = (r_state == S_RUN) && !stall_i;
  assign w_start_acc = (r_state != S_RUN) && start_i;
  assign w_pc_inc    = r_pc + 8'd1;
  assign w_pc_fwd    = r_pc + offset_i;
  assign w_pc_back   = r_pc - offset_i;

  // Fault and halt outcomes leave the PC on the offending instruction.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (w_start_acc) begin
      w_state_nxt = S_RUN;
      w_pc_nxt    = start_addr_i;
    end else if (w_retire) begin
      if (inst_i == C_INST_ILLEGAL) begin
        w_state_nxt = S_FAULT;
      end else if (inst_i == C_INST_HALT) begin
        w_state_nxt = S_HALTED;
      end else if (branch_fwd_i && branch_back_i) begin
        w_state_nxt = S_FAULT;
      end else if (taken_i && branch_fwd_i) begin
        w_pc_nxt = w_pc_fwd;
      end else if (taken_i && branch_back_i) begin
        w_pc_nxt = w_pc_back;
      end else if (r_pc == 8'hFF) begin
        w_state_nxt = S_FAULT;
      end else begin
        w_pc_nxt = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_pc    <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign pc_o         = r_pc;
  assign inst_valid_o = w_retire;
  assign busy_o       = (r_state == S_RUN);
  assign done_o       = (r_state == S_HALTED);
  assign fault_o      = (r_state == S_FAULT);

`ifdef INST_COUNT_EN
  logic [15:0] r_inst_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_inst_count <= 16'd0;
    end else if (w_start_acc) begin
      r_inst_count <= 16'd0;
    end else if (w_retire && (r_inst_count != 16'hFFFF)) begin
      r_inst_count <= r_inst_count + 16'd1;
    end
  end

  assign inst_count_o = r_inst_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : vector table, directed corner sequences and random run
// against a behavioural model. Revision: 1.0
// ============================================================================
module tb_fetch_sequencer;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       start_i, stall_i, branch_fwd_i, branch_back_i, taken_i;
  logic [7:0] start_addr_i, inst_i, offset_i;
  logic [7:0] pc_o;
  logic       inst_valid_o, busy_o, done_o, fault_o;
`ifdef INST_COUNT_EN
  logic [15:0] inst_count_o;
`endif

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
    .start_addr_i(start_addr_i), .inst_i(inst_i), .stall_i(stall_i),
    .branch_fwd_i(branch_fwd_i), .branch_back_i(branch_back_i),
    .taken_i(taken_i), .offset_i(offset_i), .pc_o(pc_o),
    .inst_valid_o(inst_valid_o), .busy_o(busy_o), .done_o(done_o),
    .fault_o(fault_o)
`ifdef INST_COUNT_EN
    , .inst_count_o(inst_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       st;
    logic [7:0] sa;
    logic [7:0] inst;
    logic       stall, f, b, t;
    logic [7:0] off;
    logic       e_valid;
    logic [7:0] e_pc;
    logic [2:0] e_flags;   // {busy, done, fault}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [7:0] sa, input logic [7:0] inst,
                     input logic stall, input logic f, input logic b, input logic t,
                     input logic [7:0] off, input logic ev, input logic [7:0] epc,
                     input logic [2:0] efl);
    vec_t v;
    v.st = st; v.sa = sa; v.inst = inst; v.stall = stall; v.f = f; v.b = b;
    v.t = t; v.off = off; v.e_valid = ev; v.e_pc = epc; v.e_flags = efl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] sa, input logic [7:0] inst,
                       input logic stall, input logic f, input logic b, input logic t,
                       input logic [7:0] off);
    start_i = st; start_addr_i = sa; inst_i = inst; stall_i = stall;
    branch_fwd_i = f; branch_back_i = b; taken_i = t; offset_i = off;
  endtask

  // Behavioural model: 0 IDLE, 1 RUN, 2 HALTED, 3 FAULT
  int m_state, m_pc, m_cnt;

  task automatic model_step(input logic st, input logic [7:0] sa, input logic [7:0] inst,
                            input logic stall, input logic f, input logic b, input logic t,
                            input logic [7:0] off);
    if (m_state != 1) begin
      if (st) begin m_state = 1; m_pc = sa; m_cnt = 0; end
    end else if (!stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (inst == 8'hFF)              m_state = 3;
      else if (inst == 8'h88)         m_state = 2;
      else if (f && b)                m_state = 3;
      else if (t && f)                m_pc = (m_pc + off) % 256;
      else if (t && b)                m_pc = (m_pc - off + 256) % 256;
      else if (m_pc == 255)           m_state = 3;
      else                            m_pc = m_pc + 1;
    end
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp);
    chk({tag, " busy"},  busy_o,  exp[2]);
    chk({tag, " done"},  done_o,  exp[1]);
    chk({tag, " fault"}, fault_o, exp[0]);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n_i = 1'b0;
    #1;
    chk("reset pc", pc_o, 0);
    chk("reset valid", inst_valid_o, 0);
    check_flags("reset", 3'b000);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;

    add(1,   0, 8'h00, 0,0,0,0,  0, 0,   0, 3'b100);
    add(0,   0, 8'h00, 0,0,0,0,  0, 1,   1, 3'b100);
    add(0,   0, 8'h00, 0,0,0,0,  0, 1,   2, 3'b100);
    add(0,   0, 8'h00, 0,0,0,0,  0, 1,   3, 3'b100);
    add(0,   0, 8'h00, 0,1,0,1, 14, 1,  17, 3'b100);
    add(0,   0, 8'h00, 0,1,0,1,  6, 1,  23, 3'b100);
    add(0,   0, 8'h00, 0,1,0,1, 24, 1,  47, 3'b100);
    add(0,   0, 8'h00, 0,0,1,1, 18, 1,  29, 3'b100);
    add(0,   0, 8'h00, 0,1,0,1, 18, 1,  47, 3'b100);
    add(0,   0, 8'h00, 0,0,1,0, 18, 1,  48, 3'b100);
    add(0,   0, 8'h00, 0,0,1,1, 38, 1,  10, 3'b100);
    add(0,   0, 8'h00, 1,1,0,1,  5, 0,  10, 3'b100);
    add(0,   0, 8'hFF, 1,1,1,1,  5, 0,  10, 3'b100);
    add(0,   0, 8'h88, 1,1,0,1,  5, 0,  10, 3'b100);
    add(0,   0, 8'h00, 0,1,0,1, 82, 1,  92, 3'b100);
    add(0,   0, 8'h88, 0,1,0,1,  3, 1,  92, 3'b010);
    add(0,   0, 8'h00, 0,1,0,1,  5, 0,  92, 3'b010);
    add(1,  93, 8'h00, 0,0,0,0,  0, 0,  93, 3'b100);
    add(0,   0, 8'h00, 0,1,0,1,105, 1, 198, 3'b100);
    add(0,   0, 8'hFF, 0,1,0,1,  1, 1, 198, 3'b001);
    add(0,   0, 8'h00, 0,1,0,1,  7, 0, 198, 3'b001);
    add(1,  50, 8'h00, 0,0,0,0,  0, 0,  50, 3'b100);
    add(0,   0, 8'h00, 0,1,1,1,  3, 1,  50, 3'b001);
    add(1, 255, 8'h00, 0,0,0,0,  0, 0, 255, 3'b100);
    add(0,   0, 8'h00, 0,0,0,0,  0, 1, 255, 3'b001);
    add(1, 250, 8'h00, 0,0,0,0,  0, 0, 250, 3'b100);
    add(0,   0, 8'h00, 0,1,0,1, 10, 1,   4, 3'b100);
    add(0,   0, 8'h00, 0,0,1,1, 10, 1, 250, 3'b100);
    add(1,   0, 8'h00, 0,0,0,0,  0, 1, 251, 3'b100);
    add(0,   0, 8'h88, 0,1,1,1,  2, 1, 251, 3'b010);

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].st, vecs[i].sa, vecs[i].inst, vecs[i].stall,
            vecs[i].f, vecs[i].b, vecs[i].t, vecs[i].off);
      #1;
      chk($sformatf("vec%0d valid", i), inst_valid_o, vecs[i].e_valid);
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d pc", i), pc_o, vecs[i].e_pc);
      check_flags($sformatf("vec%0d", i), vecs[i].e_flags);
    end

    // Asynchronous reset in the middle of a RUN cycle at pc 120
    @(negedge clk_i); drive(1, 100, 8'h00, 0, 0, 0, 0, 0);
    @(negedge clk_i); drive(0, 0, 8'h00, 0, 1, 0, 1, 20);
    @(negedge clk_i); drive(0, 0, 8'h00, 0, 0, 0, 0, 0);
    chk("pre-reset pc", pc_o, 120);
    #2 reset_n_i = 1'b0;
    #1;
    chk("async reset pc", pc_o, 0);
    chk("async reset valid", inst_valid_o, 0);
    check_flags("async reset", 3'b000);
    @(posedge clk_i); #1;
    chk("held reset pc", pc_o, 0);
    @(negedge clk_i); reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("post-release idle pc", pc_o, 0);
    check_flags("post-release", 3'b000);
    @(negedge clk_i); drive(1, 5, 8'h00, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    chk("restart pc", pc_o, 5);
    check_flags("restart", 3'b100);

    // Straight run 0..92 ending in halt
    @(negedge clk_i); drive(0, 0, 8'h00, 0, 0, 0, 0, 0);
    reset_n_i = 1'b0;
    #1 reset_n_i = 1'b1;
    drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    for (int k = 0; k < 92; k++) begin
      @(negedge clk_i); drive(0, 0, 8'h00, 0, 0, 0, 0, 0);
    end
    @(negedge clk_i); drive(0, 0, 8'h88, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    chk("run-to-halt pc", pc_o, 92);
    check_flags("run-to-halt", 3'b010);
`ifdef INST_COUNT_EN
    chk("inst_count after halt", inst_count_o, 93);
`endif

    // Randomised run against the model
    @(negedge clk_i);
    drive(0, 0, 8'h00, 0, 0, 0, 0, 0);
    reset_n_i = 1'b0;
    #1 reset_n_i = 1'b1;
    m_state = 0; m_pc = 0; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic st, stall, f, b, t;
      logic [7:0] sa, inst, off;
      int r;
      @(negedge clk_i);
      st = ($urandom_range(0, 3) == 0);
      sa = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 31);
      inst = (r == 0) ? 8'hFF : (r == 1) ? 8'h88 : 8'($urandom_range(0, 127));
      stall = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0);
      t = $urandom_range(0, 1) == 1;
      off = 8'($urandom_range(0, 255));
      drive(st, sa, inst, stall, f, b, t, off);
      #1;
      chk("rand valid", inst_valid_o, (m_state == 1) && !stall);
      model_step(st, sa, inst, stall, f, b, t, off);
      @(posedge clk_i); #1;
      chk("rand pc", pc_o, m_pc);
      check_flags("rand", {m_state == 1, m_state == 2, m_state == 3});
`ifdef INST_COUNT_EN
      chk("rand inst_count", inst_count_o, m_cnt);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
